fir_coeff_ctrl: RTL and testbench
=================================

Name: fir_coeff_ctrl

Overview:
Coefficient bank controller for the 5x5 cascaded systolic FIR. It accepts coefficient writes from a config master into a shadow bank and tracks which taps have been written. On commit it arms a swap, and copies shadow to the active bank at the next frame start (vs_i rising edge). The filter therefore never sees a partially updated kernel mid-frame. The active bank drives the filter's 25 coeff inputs directly.

Parameters:
NTAPS, 25, number of kernel taps; tap k maps to coeff{k/5}{k%5}
CW, 16, coefficient width (signed Q8.8)
ID_TAP, 12, tap index loaded with ID_VALUE at reset (kernel centre)
ID_VALUE, 16'h0100, reset value of tap ID_TAP (1.0 in Q8.8, pass-through); all other taps reset to 0
SWAP_ON_VS, 1, 1: swap at vs_i rising edge; 0: swap on the cycle after commit acceptance

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
vs_i  in  1  vertical sync from the video input, same as fed to the filter
cfg_valid  in  1  write request
cfg_ready  out  1  controller can accept a write or commit
cfg_addr  in  5  tap index 0..24
cfg_data  in  CW  coefficient value
cfg_commit  in  1  with cfg_valid: commit request (cfg_addr/cfg_data ignored)
coeff_flat  out  NTAPS*CW  active bank; tap k at bits [k*CW +: CW]
pending  out  1  swap armed, waiting for frame start
swap_done  out  1  one-cycle pulse, cycle the active bank changes
err_addr  out  1  sticky: write to cfg_addr > 24 seen
err_incomplete  out  1  sticky: commit attempted with fewer than 25 taps written
err_clr  in  1  clears both sticky errors

Behaviour:
- Reset (rst=0 at a clk edge) clears all state:
  - active and shadow banks = identity kernel (tap ID_TAP = ID_VALUE, others 0)
  - written mask = 0; pending = 0; swap_done = 0; err_* = 0
  - FSM = IDLE; vs_i edge-detect register = 0; cfg_ready = 0 during reset
- FSM states:
  - IDLE: no writes since last swap
  - LOAD: at least one tap written
  - ARMED: commit accepted, waiting for swap
  - SWAP: single cycle, copy shadow to active
- Handshake: a transfer occurs when cfg_valid & cfg_ready. cfg_ready = 1 in IDLE/LOAD, 0 in ARMED/SWAP.
- Write transfer (cfg_commit=0):
  - addr <= 24: shadow[addr] <= cfg_data; mask[addr] <= 1; IDLE -> LOAD
  - addr > 24: write ignored, err_addr <= 1, state unchanged
  - Rewriting a tap overwrites it; the mask bit stays set.
- Commit transfer (cfg_commit=1):
  - mask all ones: -> ARMED; pending = 1 from the next cycle
  - otherwise: err_incomplete <= 1, state unchanged, shadow kept
- Swap trigger:
  - vs_rise = vs_i & ~vs_d, where vs_d is vs_i registered
  - In ARMED with SWAP_ON_VS=1: vs_rise -> SWAP
  - SWAP_ON_VS=0: ARMED -> SWAP unconditionally on the next cycle
- SWAP cycle:
  - active <= shadow, mask <= 0
  - swap_done = 1 for exactly this cycle; coeff_flat shows the new kernel from the following cycle
  - pending drops to 0 in the same cycle coeff_flat changes
  - next state IDLE
- Latency:
  - commit accept at edge N: pending=1 after N
  - vs_rise sampled at edge M >= N+1: swap_done high after M, new coeff_flat after M+1
- Commit and vs_rise at the same edge: no swap this frame. The swap waits for the next vs_rise.
- vs_i held high across many cycles produces only one trigger.
- Shadow contents persist after a swap, so a full reload is required before the next commit (mask cleared).
- err_clr has priority over a same-cycle error set and clears the errors.
- coeff_flat is registered only, never combinationally derived from the shadow bank.

Test Plan:
- Reset: hold rst=0 2 cycles -> coeff_flat tap12 = 16'h0100, other taps 0; pending=0; cfg_ready=1 after release.
- Full load, taps k=0..24 with data k+1, commit, vs_i pulse 10 cycles later:
  - pending=1 until swap
  - swap_done single pulse 1 cycle after vs_rise edge
  - coeff_flat tap k = k+1 the cycle after
- Write taps 0..23 only, then commit -> err_incomplete=1, pending stays 0; then write tap 24, commit -> accepted.
- cfg_addr=5'd27, data 16'hFFFF -> err_addr=1, no mask/shadow change; err_clr -> err_addr=0.
- Commit accepted on the same edge as vs_rise:
  - no swap on that edge
  - swap_done only after the next vs rising edge
  - cfg_ready=0 throughout ARMED
- rst=0 asserted while ARMED -> pending=0, coeff_flat back to identity, a following vs pulse produces no swap_done.

Source files
------------

// File: rtl/fir_coeff_ctrl_if.sv
// Config bus for the FIR coefficient controller: tap writes and commit requests
// use a valid/ready handshake; a transfer happens on cfg_valid & cfg_ready.
interface fir_coeff_ctrl_if #(
  parameter int CW = 16
);
  logic          cfg_valid;
  logic          cfg_ready;
  logic [4:0]    cfg_addr;
  logic [CW-1:0] cfg_data;
  logic          cfg_commit;

  modport master (
    output cfg_valid, cfg_addr, cfg_data, cfg_commit,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, cfg_commit,
    output cfg_ready
  );
endinterface

// File: rtl/fir_coeff_ctrl.sv
// Double-buffered coefficient bank: writes land in shadow, swap to active at frame start.
// Swap lands one cycle after the triggering vs_i rise; cfg_ready is low while a swap is armed.
module fir_coeff_ctrl #(
  parameter int            NTAPS      = 25,
  parameter int            CW         = 16,
  parameter int            ID_TAP     = 12,
  parameter logic [CW-1:0] ID_VALUE   = 16'h0100,
  parameter bit            SWAP_ON_VS = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                vs_i,
  fir_coeff_ctrl_if.slave     cfg,
  output logic [NTAPS*CW-1:0] coeff_flat,
  output logic                pending,
  output logic                swap_done,
  output logic                err_addr,
  output logic                err_incomplete,
  input  logic                err_clr
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ARMED, S_SWAP} state_e;

  localparam logic [4:0] LAST_TAP = 5'(NTAPS - 1);

  state_e            state_q, state_d;
  logic              vs_d_q, vs_d_d;
  logic [NTAPS-1:0]  mask_q, mask_d;
  logic              err_addr_q, err_addr_d;
  logic              err_inc_q, err_inc_d;
  logic [CW-1:0]     shadow_q [NTAPS];
  logic [CW-1:0]     shadow_d [NTAPS];
  logic [CW-1:0]     active_q [NTAPS];
  logic [CW-1:0]     active_d [NTAPS];

  logic rdy, xfer, vs_rise, wr_ok, wr_bad, cmt_ok, cmt_bad;

  assign rdy     = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign xfer    = cfg.cfg_valid & rdy & rst;
  assign vs_rise = vs_i & ~vs_d_q;
  assign wr_ok   = xfer & ~cfg.cfg_commit & (cfg.cfg_addr <= LAST_TAP);
  assign wr_bad  = xfer & ~cfg.cfg_commit & (cfg.cfg_addr >  LAST_TAP);
  assign cmt_ok  = xfer &  cfg.cfg_commit & (&mask_q);
  assign cmt_bad = xfer &  cfg.cfg_commit & ~(&mask_q);

  // State register: every flop in the block, reset to the identity kernel
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      vs_d_q     <= 1'b0;
      mask_q     <= '0;
      err_addr_q <= 1'b0;
      err_inc_q  <= 1'b0;
      for (int k = 0; k < NTAPS; k++) begin
        shadow_q[k] <= (k == ID_TAP) ? ID_VALUE : '0;
        active_q[k] <= (k == ID_TAP) ? ID_VALUE : '0;
      end
    end else begin
      state_q    <= state_d;
      vs_d_q     <= vs_d_d;
      mask_q     <= mask_d;
      err_addr_q <= err_addr_d;
      err_inc_q  <= err_inc_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (cmt_ok)     state_d = S_ARMED;
        else if (wr_ok) state_d = S_LOAD;
      end
      S_ARMED: if (!SWAP_ON_VS || vs_rise) state_d = S_SWAP;
      S_SWAP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bank, mask and sticky-error updates
  always_comb begin
    vs_d_d     = vs_i;
    shadow_d   = shadow_q;
    active_d   = active_q;
    mask_d     = mask_q;
    err_addr_d = err_clr ? 1'b0 : (err_addr_q | wr_bad);
    err_inc_d  = err_clr ? 1'b0 : (err_inc_q | cmt_bad);
    if (wr_ok) begin
      shadow_d[cfg.cfg_addr] = cfg.cfg_data;
      mask_d[cfg.cfg_addr]   = 1'b1;
    end
    if (state_q == S_SWAP) begin
      active_d = shadow_q;
      mask_d   = '0;
    end
  end

  // Outputs
  always_comb begin
    cfg.cfg_ready  = rdy & rst;
    pending        = (state_q == S_ARMED) || (state_q == S_SWAP);
    swap_done      = (state_q == S_SWAP);
    err_addr       = err_addr_q;
    err_incomplete = err_inc_q;
    coeff_flat     = '0;
    for (int k = 0; k < NTAPS; k++) begin
      coeff_flat[k*CW +: CW] = active_q[k];
    end
  end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// Directed bench for fir_coeff_ctrl: reset, load/commit/swap, error paths, commit on vs edge.
module tb_fir_coeff_ctrl;
  localparam int NTAPS = 25;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic rst, vs_i, err_clr;
  logic [NTAPS*CW-1:0] coeff_flat;
  logic pending, swap_done, err_addr, err_incomplete;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fir_coeff_ctrl_if #(.CW(CW)) cfg_if ();

  fir_coeff_ctrl #(.NTAPS(NTAPS), .CW(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .vs_i           (vs_i),
    .cfg            (cfg_if.slave),
    .coeff_flat     (coeff_flat),
    .pending        (pending),
    .swap_done      (swap_done),
    .err_addr       (err_addr),
    .err_incomplete (err_incomplete),
    .err_clr        (err_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] tap(input int k);
    return coeff_flat[k*CW +: CW];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [4:0] addr, input logic [CW-1:0] data);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_commit = 1'b0;
    cfg_if.cfg_addr   = addr;
    cfg_if.cfg_data   = data;
    step();
    cfg_if.cfg_valid  = 1'b0;
  endtask

  task automatic cfg_commit_req();
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_commit = 1'b1;
    step();
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_commit = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    vs_i = 1'b0;
    err_clr = 1'b0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_commit = 1'b0;
    cfg_if.cfg_addr   = '0;
    cfg_if.cfg_data   = '0;

    // Reset state
    step();
    check("ready_in_reset", cfg_if.cfg_ready, 1'b0);
    step();
    check("rst_tap12", tap(12), 16'h0100);
    check("rst_tap0", tap(0), 16'h0000);
    check("rst_tap24", tap(24), 16'h0000);
    check("rst_pending", pending, 1'b0);
    check("rst_swap_done", swap_done, 1'b0);
    check("rst_err_addr", err_addr, 1'b0);
    check("rst_err_inc", err_incomplete, 1'b0);
    rst = 1'b1;
    #1;
    check("ready_after_rst", cfg_if.cfg_ready, 1'b1);

    // Incomplete load rejected, then completed and accepted
    for (int k = 0; k < 24; k++) cfg_write(5'(k), 16'(k + 1));
    cfg_commit_req();
    check("inc_err", err_incomplete, 1'b1);
    check("inc_pending", pending, 1'b0);
    check("inc_ready", cfg_if.cfg_ready, 1'b1);
    cfg_write(5'd24, 16'd25);
    cfg_commit_req();
    check("cmt_pending", pending, 1'b1);
    check("cmt_ready", cfg_if.cfg_ready, 1'b0);
    check("cmt_tap12_old", tap(12), 16'h0100);
    for (int i = 0; i < 10; i++) begin
      step();
      check("armed_pending", pending, 1'b1);
      check("armed_no_swap", swap_done, 1'b0);
    end
    vs_i = 1'b1;
    step();
    check("swap_pulse", swap_done, 1'b1);
    check("swap_pending", pending, 1'b1);
    check("swap_tap0_old", tap(0), 16'h0000);
    step();
    check("post_swap_done", swap_done, 1'b0);
    check("post_swap_pending", pending, 1'b0);
    check("post_swap_ready", cfg_if.cfg_ready, 1'b1);
    for (int k = 0; k < NTAPS; k++) check("new_tap", tap(k), 64'(k + 1));
    for (int i = 0; i < 3; i++) begin
      step();
      check("vs_held_no_swap", swap_done, 1'b0);
    end
    vs_i = 1'b0;

    // Out-of-range address, err_clr
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("clr_err_inc", err_incomplete, 1'b0);
    cfg_write(5'd27, 16'hFFFF);
    check("bad_addr_err", err_addr, 1'b1);
    check("bad_addr_ready", cfg_if.cfg_ready, 1'b1);
    cfg_commit_req();
    check("bad_addr_mask", err_incomplete, 1'b1);
    check("bad_addr_pending", pending, 1'b0);
    err_clr = 1'b1;
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = 5'd31;
    step();
    err_clr = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    check("clr_prio_addr", err_addr, 1'b0);
    check("clr_prio_inc", err_incomplete, 1'b0);

    // Commit accepted on the same edge as vs rise
    for (int k = 0; k < NTAPS; k++) cfg_write(5'(k), 16'(3 * k));
    vs_i = 1'b1;
    cfg_commit_req();
    check("same_edge_pending", pending, 1'b1);
    check("same_edge_no_swap", swap_done, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("same_edge_wait", swap_done, 1'b0);
      check("same_edge_ready", cfg_if.cfg_ready, 1'b0);
    end
    vs_i = 1'b0;
    step();
    check("gap_ready", cfg_if.cfg_ready, 1'b0);
    vs_i = 1'b1;
    step();
    check("next_vs_swap", swap_done, 1'b1);
    step();
    vs_i = 1'b0;
    check("k3_tap0", tap(0), 16'd0);
    check("k3_tap12", tap(12), 16'd36);
    check("k3_tap24", tap(24), 16'd72);

    // Reset while armed
    for (int k = 0; k < NTAPS; k++) cfg_write(5'(k), 16'h0F00 | 16'(k));
    cfg_commit_req();
    check("rarm_pending", pending, 1'b1);
    rst = 1'b0;
    step();
    check("rarm_pending_clr", pending, 1'b0);
    check("rarm_tap12", tap(12), 16'h0100);
    check("rarm_tap24", tap(24), 16'h0000);
    rst = 1'b1;
    vs_i = 1'b1;
    step();
    check("rarm_no_swap0", swap_done, 1'b0);
    step();
    check("rarm_no_swap1", swap_done, 1'b0);
    check("rarm_ready", cfg_if.cfg_ready, 1'b1);
    vs_i = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
